// File: rtl/wishbone_rr_arbiter.sv
// Round-robin arbiter that shares one pipelined Wishbone target among
// NumInitiators initiators. A grant is held for the whole CYC of the winner.
// Accepted-but-unterminated requests are counted and capped, and a watchdog
// aborts a hung target by returning ERR to the granted initiator.
//
// Handshake: a request transfers on a cycle where STB=1 and STALL=0; each
// accepted request is later terminated by exactly one of ACK/ERR/RTY.
module wishbone_rr_arbiter #(
  parameter int NumInitiators  = 4,
  parameter int AddressWidth   = 16,
  parameter int DataWidth      = 8,
  parameter int Granularity    = 8,
  parameter int MaxOutstanding = 4,
  parameter int Timeout        = 255,
  localparam int SelWidth      = DataWidth / Granularity
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NumInitiators-1:0]          i_cyc,
  input  logic [NumInitiators-1:0]          i_stb,
  input  logic [NumInitiators-1:0]          i_we,
  input  logic [NumInitiators-1:0]          i_lock,
  input  logic [NumInitiators*AddressWidth-1:0] i_addr,
  input  logic [NumInitiators*DataWidth-1:0]    i_dat_w,
  input  logic [NumInitiators*SelWidth-1:0]     i_sel,
  output logic [DataWidth-1:0]              i_dat_r,
  output logic [NumInitiators-1:0]          i_ack,
  output logic [NumInitiators-1:0]          i_err,
  output logic [NumInitiators-1:0]          i_rty,
  output logic [NumInitiators-1:0]          i_stall,
  output logic                              t_cyc,
  output logic                              t_stb,
  output logic                              t_we,
  output logic                              t_lock,
  output logic [AddressWidth-1:0]           t_addr,
  output logic [DataWidth-1:0]              t_dat_w,
  output logic [SelWidth-1:0]               t_sel,
  input  logic [DataWidth-1:0]              t_dat_r,
  input  logic                              t_ack,
  input  logic                              t_err,
  input  logic                              t_rty,
  input  logic                              t_stall,
  output logic [NumInitiators-1:0]          gnt,
  output logic [1:0]                        state_dbg
);

  localparam int IW = $clog2(NumInitiators);
  localparam int OW = $clog2(MaxOutstanding + 1);
  localparam int WW = $clog2(Timeout);
  localparam logic [OW-1:0] MaxOut  = OW'(MaxOutstanding);
  localparam logic [WW-1:0] WdLast  = WW'(Timeout - 2);
  localparam logic [IW-1:0] LastIdx = IW'(NumInitiators - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic [OW-1:0]   outst;
  logic [WW-1:0]   wd;
  logic            abort_first;

  logic            req_any;
  logic [IW-1:0]   req_pick;
  logic            term;
  logic            accept;
  logic            room;
  logic [IW-1:0]   ptr_after;

  assign state_dbg = state;
  assign i_dat_r   = t_dat_r;
  assign term      = t_ack | t_err | t_rty;
  assign room      = (outst != MaxOut);
  assign accept    = t_stb & ~t_stall;
  assign ptr_after = (gidx == LastIdx) ? '0 : gidx + 1'b1;

  // Pick the first requester at or after the rr pointer, wrapping around.
  always_comb begin
    int idx;
    req_any  = 1'b0;
    req_pick = '0;
    idx      = 0;
    for (int k = 0; k < NumInitiators; k++) begin
      idx = (int'(ptr) + k) % NumInitiators;
      if (!req_any && i_cyc[idx]) begin
        req_any  = 1'b1;
        req_pick = IW'(idx);
      end
    end
  end

  // Route the granted initiator to the target and responses back to it.
  always_comb begin
    t_cyc   = 1'b0;
    t_stb   = 1'b0;
    t_we    = 1'b0;
    t_lock  = 1'b0;
    t_addr  = '0;
    t_dat_w = '0;
    t_sel   = '0;
    i_ack   = '0;
    i_err   = '0;
    i_rty   = '0;
    i_stall = '1;
    if (state == ST_GRANT) begin
      t_cyc         = i_cyc[gidx];
      t_stb         = i_cyc[gidx] & i_stb[gidx] & room;
      t_we          = i_we[gidx];
      t_lock        = i_lock[gidx];
      t_addr        = i_addr[int'(gidx)*AddressWidth +: AddressWidth];
      t_dat_w       = i_dat_w[int'(gidx)*DataWidth +: DataWidth];
      t_sel         = i_sel[int'(gidx)*SelWidth +: SelWidth];
      i_stall[gidx] = t_stall | ~room;
      i_ack[gidx]   = t_ack;
      i_err[gidx]   = t_err;
      i_rty[gidx]   = t_rty;
    end else if (state == ST_ABORT) begin
      i_err[gidx] = abort_first;
    end
  end

  // Arbitration FSM with outstanding counter and watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      gidx        <= '0;
      gnt         <= '0;
      outst       <= '0;
      wd          <= '0;
      abort_first <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          outst       <= '0;
          wd          <= '0;
          abort_first <= 1'b0;
          if (req_any) begin
            gidx          <= req_pick;
            gnt           <= '0;
            gnt[req_pick] <= 1'b1;
            state         <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!i_cyc[gidx]) begin
            // Grant ends at the first low CYC; unterminated requests are dropped.
            state <= ST_IDLE;
            ptr   <= ptr_after;
            gnt   <= '0;
            outst <= '0;
            wd    <= '0;
          end else begin
            if (accept && !term) begin
              outst <= outst + OW'(1);
            end else if (term && !accept && outst != '0) begin
              outst <= outst - OW'(1);
            end
            if (term || outst == '0) begin
              wd <= '0;
            end else if (wd == WdLast) begin
              wd          <= '0;
              abort_first <= 1'b1;
              state       <= ST_ABORT;
            end else begin
              wd <= wd + WW'(1);
            end
          end
        end
        ST_ABORT: begin
          abort_first <= 1'b0;
          outst       <= '0;
          wd          <= '0;
          if (!i_cyc[gidx]) begin
            state <= ST_IDLE;
            ptr   <= ptr_after;
            gnt   <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Directed bench for wishbone_rr_arbiter: four initiators, MaxOutstanding=4,
// Timeout=8. Inputs change 1ns after the rising edge, outputs are sampled a
// further 1ns later.
module tb_wishbone_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int SW = 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ABORT = 2'd2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    i_cyc, i_stb, i_we, i_lock;
  logic [N*AW-1:0] i_addr;
  logic [N*DW-1:0] i_dat_w;
  logic [N*SW-1:0] i_sel;
  logic [DW-1:0]   i_dat_r;
  logic [N-1:0]    i_ack, i_err, i_rty, i_stall;
  logic            t_cyc, t_stb, t_we, t_lock;
  logic [AW-1:0]   t_addr;
  logic [DW-1:0]   t_dat_w;
  logic [SW-1:0]   t_sel;
  logic [DW-1:0]   t_dat_r;
  logic            t_ack, t_err, t_rty, t_stall;
  logic [N-1:0]    gnt;
  logic [1:0]      state_dbg;

  int checks;
  int errors;

  wishbone_rr_arbiter #(
    .NumInitiators(N), .AddressWidth(AW), .DataWidth(DW), .Granularity(8),
    .MaxOutstanding(4), .Timeout(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_lock(i_lock),
    .i_addr(i_addr), .i_dat_w(i_dat_w), .i_sel(i_sel),
    .i_dat_r(i_dat_r), .i_ack(i_ack), .i_err(i_err), .i_rty(i_rty),
    .i_stall(i_stall),
    .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_lock(t_lock),
    .t_addr(t_addr), .t_dat_w(t_dat_w), .t_sel(t_sel), .t_dat_r(t_dat_r),
    .t_ack(t_ack), .t_err(t_err), .t_rty(t_rty), .t_stall(t_stall),
    .gnt(gnt), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_cyc = '0; i_stb = '0; i_we = '0; i_lock = '0;
    t_ack = 1'b0; t_err = 1'b0; t_rty = 1'b0; t_stall = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || t_cyc !== 1'b0 || t_stb !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got gnt=%b cyc=%b stb=%b want 0000 0 0", gnt, t_cyc, t_stb);
    end
    checks++;
    if (i_stall !== 4'b1111 || i_ack !== 4'b0000 || i_err !== 4'b0000 || i_rty !== 4'b0000) begin
      errors++;
      $display("FAIL reset_resp: got stall=%b ack=%b err=%b rty=%b want 1111 0 0 0",
               i_stall, i_ack, i_err, i_rty);
    end
    checks++;
    if (state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d want %0d", state_dbg, S_IDLE);
    end
  endtask

  task automatic test_single_grant();
    i_cyc = 4'b0001;
    #1;
    checks++;
    if (gnt !== 4'b0000 || t_cyc !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: got gnt=%b cyc=%b want 0000 0", gnt, t_cyc);
    end
    step();
    checks++;
    if (gnt !== 4'b0001 || t_cyc !== 1'b1 || i_stall !== 4'b1110) begin
      errors++;
      $display("FAIL single_grant: got gnt=%b cyc=%b stall=%b want 0001 1 1110", gnt, t_cyc, i_stall);
    end
    i_cyc = 4'b0000;
    step();
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL single_release: got gnt=%b want 0000", gnt);
    end
    // pointer is now 1, so initiator 1 wins over 0
    i_cyc = 4'b0011;
    step();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL single_pointer: got gnt=%b want 0010", gnt);
    end
    i_cyc = 4'b0000;
    step();
  endtask

  task automatic test_round_robin();
    int g;
    logic [N-1:0] exp_gnt;
    logic [AW-1:0] exp_addr;
    do_reset();
    i_cyc = 4'b1111;
    for (int it = 0; it < 5; it++) begin
      g = it % N;
      exp_gnt = 4'b0001 << g;
      exp_addr = 16'hA000 + AW'(g);
      step();
      checks++;
      if (gnt !== exp_gnt || t_cyc !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got gnt=%b cyc=%b want %b 1", it, gnt, t_cyc, exp_gnt);
      end
      i_stb[g] = 1'b1;
      #1;
      checks++;
      if (t_stb !== 1'b1 || t_addr !== exp_addr) begin
        errors++;
        $display("FAIL rr_req[%0d]: got stb=%b addr=%h want 1 %h", it, t_stb, t_addr, exp_addr);
      end
      step();
      i_stb[g] = 1'b0;
      t_ack = 1'b1;
      #1;
      checks++;
      if (i_ack !== exp_gnt) begin
        errors++;
        $display("FAIL rr_ack[%0d]: got %b want %b", it, i_ack, exp_gnt);
      end
      step();
      t_ack = 1'b0;
      i_cyc[g] = 1'b0;
      step();
      checks++;
      if (gnt !== 4'b0000) begin
        errors++;
        $display("FAIL rr_dead_cycle[%0d]: got gnt=%b want 0000", it, gnt);
      end
      i_cyc[g] = 1'b1;
    end
    i_cyc = 4'b0000;
    step();
    step();
  endtask

  task automatic test_max_outstanding();
    logic exp_stb;
    do_reset();
    i_cyc = 4'b0100;
    step();
    i_stb = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      exp_stb = (k < 4);
      #1;
      checks++;
      if (t_stb !== exp_stb || i_stall[2] !== !exp_stb) begin
        errors++;
        $display("FAIL max_cap[%0d]: got stb=%b stall2=%b want %b %b", k, t_stb, i_stall[2], exp_stb, !exp_stb);
      end
      step();
    end
    t_ack = 1'b1;
    #1;
    checks++;
    if (i_ack !== 4'b0100 || t_stb !== 1'b0) begin
      errors++;
      $display("FAIL max_ack_full: got ack=%b stb=%b want 0100 0", i_ack, t_stb);
    end
    step();
    t_ack = 1'b0;
    #1;
    checks++;
    if (t_stb !== 1'b1 || i_stall !== 4'b1011) begin
      errors++;
      $display("FAIL max_release: got stb=%b stall=%b want 1 1011", t_stb, i_stall);
    end
    step();
    checks++;
    if (t_stb !== 1'b0) begin
      errors++;
      $display("FAIL max_refull: got stb=%b want 0", t_stb);
    end
    t_ack = 1'b1;
    step();
    // outstanding is 3: accept and ACK in the same cycle
    checks++;
    if (t_stb !== 1'b1 || i_ack !== 4'b0100) begin
      errors++;
      $display("FAIL same_cycle: got stb=%b ack=%b want 1 0100", t_stb, i_ack);
    end
    step();
    t_ack = 1'b0;
    #1;
    checks++;
    if (t_stb !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_hold3: got stb=%b want 1", t_stb);
    end
    step();
    checks++;
    if (t_stb !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_now4: got stb=%b want 0", t_stb);
    end
    i_stb = 4'b0000;
    i_cyc = 4'b0000;
    step();
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL max_release_grant: got gnt=%b want 0000", gnt);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    i_cyc = 4'b0010;
    step();
    i_stb = 4'b0010;
    step();
    i_stb = 4'b0000;
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (i_err[1] === 1'b1) begin
        n = c;
        break;
      end
    end
    checks++;
    if (n != 7) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d want 7", n);
    end
    checks++;
    if (t_cyc !== 1'b0 || i_err !== 4'b0010 || state_dbg !== S_ABORT) begin
      errors++;
      $display("FAIL abort_entry: got cyc=%b err=%b state=%0d want 0 0010 %0d", t_cyc, i_err, state_dbg, S_ABORT);
    end
    t_ack = 1'b1;
    step();
    checks++;
    if (i_err !== 4'b0000 || i_ack !== 4'b0000 || t_cyc !== 1'b0 || i_stall !== 4'b1111) begin
      errors++;
      $display("FAIL abort_ignore: got err=%b ack=%b cyc=%b stall=%b want 0000 0000 0 1111",
               i_err, i_ack, t_cyc, i_stall);
    end
    t_ack = 1'b0;
    i_cyc = 4'b0000;
    step();
    checks++;
    if (gnt !== 4'b0000 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL abort_exit: got gnt=%b state=%0d want 0000 %0d", gnt, state_dbg, S_IDLE);
    end
  endtask

  task automatic test_reset_mid_burst();
    // pointer is 2 after the abort of initiator 1
    i_cyc = 4'b1010;
    step();
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL mid_pre_grant: got gnt=%b want 1000", gnt);
    end
    i_stb = 4'b1000;
    step();
    step();
    i_stb = 4'b0000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (t_cyc !== 1'b0 || gnt !== 4'b0000 || i_stall !== 4'b1111) begin
      errors++;
      $display("FAIL mid_reset: got cyc=%b gnt=%b stall=%b want 0 0000 1111", t_cyc, gnt, i_stall);
    end
    step();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL mid_rearb: got gnt=%b want 0010", gnt);
    end
    i_cyc = 4'b0000;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    i_cyc = '0; i_stb = '0; i_we = '0; i_lock = '0;
    i_dat_w = '0; i_sel = '1;
    t_dat_r = 8'h5A;
    t_ack = 1'b0; t_err = 1'b0; t_rty = 1'b0; t_stall = 1'b0;
    for (int i = 0; i < N; i++) begin
      i_addr[i*AW +: AW] = 16'hA000 + AW'(i);
    end
    test_reset();
    test_single_grant();
    test_round_robin();
    test_max_outstanding();
    test_timeout();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wishbone_rr_arbiter.md
Name: wishbone_rr_arbiter

Overview:
- Shares one pipelined-mode Wishbone target among NumInitiators initiators.
- Uses round-robin arbitration. A grant is held for the whole CYC of the winning initiator.
- Tracks outstanding requests, caps them at MaxOutstanding, and aborts a hung target with a watchdog timeout that returns ERR.
- Sits between the initiator-side skid buffers and a shared target such as a memory or peripheral bus.

Parameters:
NumInitiators, 4, number of requesters (2..16)
AddressWidth, 16, address bits
DataWidth, 8, data bits (8/16/32/64)
Granularity, 8, SEL granularity; SELW = DataWidth/Granularity
MaxOutstanding, 4, maximum accepted-but-unterminated requests (≥1)
Timeout, 255, cycles without termination while outstanding>0 before abort (≥2)

Ports:
SysCon.CLK  input  1  clock; all logic on rising edge
SysCon.RST  input  1  synchronous active-high reset
I_CYC  input  N  per-initiator CYC; also the request line
I_STB  input  N  per-initiator STB
I_WE  input  N  per-initiator WE
I_LOCK  input  N  per-initiator LOCK (passed through)
I_ADDR  input  N*AddressWidth  packed addresses; initiator i at slice i
I_DAT_W  input  N*DataWidth  packed write data
I_SEL  input  N*SELW  packed byte selects
I_DAT_R  output  DataWidth  read data, broadcast to all initiators
I_ACK  output  N  per-initiator ACK
I_ERR  output  N  per-initiator ERR
I_RTY  output  N  per-initiator RTY
I_STALL  output  N  per-initiator STALL
T_CYC, T_STB, T_WE, T_LOCK  output  1 each  target control
T_ADDR  output  AddressWidth  target address
T_DAT_W  output  DataWidth  target write data
T_SEL  output  SELW  target byte selects
T_DAT_R  input  DataWidth  target read data
T_ACK, T_ERR, T_RTY, T_STALL  input  1 each  target responses
GNT  output  N  one-hot current grant; 0 when idle

Behaviour:

Reset:
- State IDLE, rr pointer 0, GNT 0, outstanding 0, watchdog 0.
- T_CYC/T_STB 0; all I_STALL 1; all I_ACK/I_ERR/I_RTY 0.
- All registered outputs take these values in the cycle after RST is sampled high.
- Reset mid-transfer drops T_CYC immediately and does not wait for ACKs.

States: IDLE, GRANT, ABORT.

IDLE:
- If any I_CYC is set, choose the first requester at index ≥ pointer, wrapping modulo N.
- GNT is registered, so there is one cycle of arbitration latency. The next state is GRANT.
- T_CYC stays 0 while in IDLE.

GRANT (granted initiator g):
- T_CYC = I_CYC[g].
- T_STB = I_STB[g] & (outstanding < MaxOutstanding).
- ADDR/DAT_W/SEL/WE/LOCK are muxed from g. In IDLE/ABORT these outputs are driven 0.
- I_STALL[g] = T_STALL | (outstanding == MaxOutstanding).
- I_ACK/ERR/RTY[g] = the corresponding T_ signal.
- Non-granted initiators get STALL=1 and ACK/ERR/RTY=0.

Outstanding counter:
- +1 on (T_STB & !T_STALL); −1 on (T_ACK|T_ERR|T_RTY).
- Both in the same cycle leaves it unchanged.
- A termination arriving with count 0 is ignored; the counter saturates at 0.

Leaving GRANT:
- When I_CYC[g] falls: next state IDLE, pointer = (g+1) mod N, GNT=0, outstanding forced to 0.
- There is one dead cycle between successive grants, even when another request is already pending.

Watchdog:
- Increments each GRANT cycle with outstanding>0 and no termination.
- Clears on any termination or when outstanding==0.
- Reaching Timeout−1: next state ABORT.

ABORT:
- T_CYC/T_STB are 0.
- I_ERR[g] pulses exactly one cycle, in the first ABORT cycle; I_STALL[g]=1.
- Target responses are ignored.
- Stays in ABORT until I_CYC[g]=0; then IDLE with pointer = g+1.

Other rules:
- An initiator that drops CYC before being granted is simply not considered at the next arbitration.
- Flapping CYC while granted ends the grant at the first low cycle.

Test Plan:
- Reset then I_CYC=4'b0001: GNT=0001 one cycle later; T_CYC=1. Drop CYC → GNT=0 next cycle; pointer=1.
- I_CYC=4'b1111 held, each initiator doing one single read and then dropping CYC: grant order 0,1,2,3,0. Exactly one idle cycle between grants.
- MaxOutstanding=4, initiator 2 issues 6 STBs with T_ACK held low: 4 accepted, then I_STALL[2]=1 and T_STB=0. Each ACK releases one more.
- Target never ACKs, Timeout=8: in the ABORT entry cycle T_CYC=0; I_ERR[g]=1 for one cycle; later target ACKs are not forwarded.
- T_STB accepted and T_ACK in the same cycle with outstanding=3: outstanding stays 3; ACK forwarded only to g.
- RST asserted mid-burst with outstanding=2: next cycle T_CYC=0, GNT=0, all I_STALL=1; re-arbitration starts at initiator 0.
